pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for WIDTH-bit operands. Operands are split into BLOCK-bit lookahead groups, with one register stage per group; the group carry ripples forward through the pipeline. A valid/ready handshake on both sides gives one operation per cycle throughput with full back-pressure. The block is the general-width successor of the team's 4-bit lookahead adder, for datapaths wider than 4 bits that need timing closure at clock rate.

---
 rtl/pipelined_cla_adder_if.sv | 26 ++
 rtl/pipelined_cla_adder.sv | 120 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for pipelined_cla_adder
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead add/sub, one BLOCK-bit group per stage
// Optional signed overflow output enabled by defining CLA_OVF_EN.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int N   = WIDTH / BLOCK;
    localparam int OPS = (N > 1) ? N - 1 : 1;

    function automatic logic [BLOCK:0] cla_group(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             c0);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // Stage k register: result groups 0..k, carry out of group k, operands still pending.
    logic             valid_q [N];
    logic             carry_q [N];
    logic [WIDTH-1:0] res_q   [N];
    logic [WIDTH-1:0] opa_q   [OPS];
    logic [WIDTH-1:0] opb_q   [OPS];

    logic             valid_d [N];
    logic             carry_d [N];
    logic [WIDTH-1:0] res_d   [N];

    logic [WIDTH-1:0] st_a    [N];
    logic [WIDTH-1:0] st_b    [N];
    logic [WIDTH-1:0] st_res  [N];
    logic             st_v    [N];
    logic             st_c    [N];
    logic [BLOCK:0]   grp     [N];

    logic adv;

    assign adv          = !valid_q[N-1] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = valid_q[N-1];
    assign bus.sum      = res_q[N-1];
    assign bus.cout     = carry_q[N-1];

    always_comb begin
        st_a[0]   = bus.a;
        st_b[0]   = bus.sub ? ~bus.b : bus.b;
        st_c[0]   = bus.sub | bus.cin;
        st_v[0]   = bus.in_valid;
        st_res[0] = '0;
        for (int k = 1; k < N; k++) begin
            st_a[k]   = opa_q[k-1];
            st_b[k]   = opb_q[k-1];
            st_c[k]   = carry_q[k-1];
            st_v[k]   = valid_q[k-1];
            st_res[k] = res_q[k-1];
        end
        for (int k = 0; k < N; k++) begin
            grp[k]     = cla_group(st_a[k][k*BLOCK +: BLOCK], st_b[k][k*BLOCK +: BLOCK], st_c[k]);
            res_d[k]   = st_res[k];
            res_d[k][k*BLOCK +: BLOCK] = grp[k][BLOCK-1:0];
            carry_d[k] = grp[k][BLOCK];
            valid_d[k] = st_v[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                res_q[k]   <= '0;
            end
            for (int j = 0; j < OPS; j++) begin
                opa_q[j] <= '0;
                opb_q[j] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < N; k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                res_q[k]   <= res_d[k];
            end
            for (int j = 0; j < OPS; j++) begin
                opa_q[j] <= st_a[j];
                opb_q[j] <= st_b[j];
            end
        end
    end

`ifdef CLA_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = st_a[N-1][WIDTH-1] ^ st_b[N-1][WIDTH-1] ^ grp[N-1][BLOCK-1] ^ grp[N-1][BLOCK];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - randomized bench with arithmetic reference model for pipelined_cla_adder
module tb_pipelined_cla_adder;
    localparam int W   = 16;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(W)) bus_if ();

    pipelined_cla_adder #(.WIDTH(W), .BLOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit strict = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        bit           seen;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        int          sa;
        int          sb;
        int          s;
        logic [W:0]  t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            e.sum  = W'(a - b);
            e.cout = (a >= b);
            s      = sa - sb;
        end else begin
            t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e.sum  = t[W-1:0];
            e.cout = t[W];
            s      = sa + sb + int'(cin);
        end
`ifdef CLA_OVF_EN
        e.ovf = (s > 32767) || (s < -32768);
`else
        e.ovf = 1'b0;
`endif
        e.acc  = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_ovf;
    bit           hold = 1'b0;
    exp_t         pend;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", {31'b0, bus_if.out_valid}, 32'd1);
                check("hold_sum", {16'b0, bus_if.sum}, {16'b0, h_sum});
                check("hold_cout_ovf", {30'b0, bus_if.cout, bus_if.ovf}, {30'b0, h_cout, h_ovf});
            end
            if (bus_if.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    check("sum", {16'b0, bus_if.sum}, {16'b0, q[0].sum});
                    check("cout", {31'b0, bus_if.cout}, {31'b0, q[0].cout});
                    check("ovf", {31'b0, bus_if.ovf}, {31'b0, q[0].ovf});
                    if (!q[0].seen) begin
                        if (strict) check("latency", cyc - q[0].acc, LAT);
                        q[0].seen = 1'b1;
                    end
                end
            end
            if (bus_if.out_valid && !bus_if.out_ready)
                check("stall_in_ready", {31'b0, bus_if.in_ready}, 32'd0);
            hold   = bus_if.out_valid && !bus_if.out_ready;
            h_sum  = bus_if.sum;
            h_cout = bus_if.cout;
            h_ovf  = bus_if.ovf;
            if (bus_if.out_valid && bus_if.out_ready && q.size() > 0) void'(q.pop_front());
            if (bus_if.in_valid && bus_if.in_ready) begin
                pend     = model(bus_if.a, bus_if.b, bus_if.cin, bus_if.sub);
                pend.acc = cyc;
                q.push_back(pend);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int t  = 0;
        bit ok = 1'b0;
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.cin      = cin;
        bus_if.sub      = sub;
        bus_if.in_valid = 1'b1;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = bus_if.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        int t = 0;
        send(a, b, cin, sub);
        while (!bus_if.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_sum"}, {16'b0, bus_if.sum}, {16'b0, es});
        check({name, "_cout"}, {31'b0, bus_if.cout}, {31'b0, ec});
        check({name, "_ovf"}, {31'b0, bus_if.ovf}, {31'b0, eo});
        idle(1);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || bus_if.out_valid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) check("drain_timeout", 32'd0, 32'd1);
    endtask

`ifdef CLA_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.cin       = 1'b0;
        bus_if.sub       = 1'b0;
        bus_if.out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
        check("rst_sum", {16'b0, bus_if.sum}, 32'd0);
        check("rst_cout_ovf", {30'b0, bus_if.cout, bus_if.ovf}, 32'd0);
        check("rst_in_ready", {31'b0, bus_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_eq", 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_EXP);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF_EXP);
        directed("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

        strict = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand();
            end
            begin
                idle(6);
                bus_if.out_ready = 1'b0;
                idle(3);
                bus_if.out_ready = 1'b1;
            end
        join
        drain();
        strict = 1'b1;

        for (int i = 0; i < 30; i++) begin
            send_rand();
            idle($urandom_range(0, 1));
        end
        drain();

        for (int i = 0; i < 3; i++) send_rand();
        rst             = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.a        = 16'h4321;
        bus_if.b        = 16'h1111;
        bus_if.sub      = 1'b0;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
        check("flush_sum", {16'b0, bus_if.sum}, 32'd0);
        idle(8);
        directed("post_rst", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
